// File: rtl/fft_frame_sched.sv
// fft_frame_sched: grants one shared fft_256 a whole frame at a time, round-robin between two
// requesters, and routes each output frame back to its issuer through an owner-tag FIFO.
module fft_frame_sched #(
    parameter int FRAME_LEN    = 256,
    parameter int DW           = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic          req0_inv,
    input  logic          req1_inv,
    input  logic [DW-1:0] req0_re,
    input  logic [DW-1:0] req0_im,
    input  logic [DW-1:0] req1_re,
    input  logic [DW-1:0] req1_im,
    output logic          fft_valid_in,
    output logic          fft_sop_in,
    output logic          fft_inv,
    output logic [DW-1:0] fft_x_re,
    output logic [DW-1:0] fft_x_im,
    input  logic          fft_valid_out,
    input  logic          fft_sop_out,
    input  logic [DW-1:0] fft_y_re,
    input  logic [DW-1:0] fft_y_im,
    output logic          out0_valid,
    output logic          out1_valid,
    output logic          out_sop,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          busy,
    output logic          err
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int PW = MAX_INFLIGHT > 1 ? $clog2(MAX_INFLIGHT) : 1;
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;

    logic                    owner, inv_r, rr, out_active, out_owner;
    logic [CW-1:0]           cnt, ocnt, idx;
    logic [IW-1:0]           inflight, fcnt;
    logic [PW-1:0]           wp, rp;
    logic [MAX_INFLIGHT-1:0] tags;
    logic                    grant, winner, accept, last, sop_v, pop, emit, done, own_eff;

    always_comb begin
        grant   = state == IDLE && inflight < IW'(MAX_INFLIGHT) && (req0_valid || req1_valid);
        winner  = (req0_valid && req1_valid) ? rr : req1_valid;
        accept  = state == STREAM && (owner ? req1_valid : req0_valid);
        last    = accept && cnt == CW'(FRAME_LEN - 1);
        sop_v   = fft_valid_out && fft_sop_out;
        pop     = sop_v && fcnt != '0;
        emit    = pop || (fft_valid_out && !fft_sop_out && out_active);
        idx     = sop_v ? '0 : ocnt;
        own_eff = sop_v ? tags[rp] : out_owner;
        done    = emit && idx == CW'(FRAME_LEN - 1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb state_nx = grant ? STREAM : last ? IDLE : state;

    always_comb begin
        req0_ready = state == STREAM && !owner;
        req1_ready = state == STREAM && owner;
        busy       = state == STREAM;
        fft_inv    = inv_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= 1'b0;
            inv_r        <= 1'b0;
            rr           <= 1'b0;
            cnt          <= '0;
            fft_valid_in <= 1'b0;
            fft_sop_in   <= 1'b0;
            fft_x_re     <= '0;
            fft_x_im     <= '0;
            tags         <= '0;
            wp           <= '0;
            rp           <= '0;
            fcnt         <= '0;
            inflight     <= '0;
        end else begin
            fft_valid_in <= accept;
            fft_sop_in   <= accept && cnt == '0;
            if (grant) begin
                owner    <= winner;
                inv_r    <= winner ? req1_inv : req0_inv;
                cnt      <= '0;
                tags[wp] <= winner;
                wp       <= wp == PW'(MAX_INFLIGHT - 1) ? '0 : wp + PW'(1);
            end
            if (accept) begin
                fft_x_re <= owner ? req1_re : req0_re;
                fft_x_im <= owner ? req1_im : req0_im;
                cnt      <= cnt + CW'(1);
            end
            if (last) rr <= ~owner;
            if (pop) rp <= rp == PW'(MAX_INFLIGHT - 1) ? '0 : rp + PW'(1);
            fcnt     <= fcnt + IW'(grant) - IW'(pop);
            inflight <= inflight + IW'(grant) - IW'(done);
        end
    end

    // A sop arriving with no outstanding tag drops the frame; one arriving mid-frame takes over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
            out_sop    <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_owner  <= 1'b0;
            out_active <= 1'b0;
            ocnt       <= '0;
            err        <= 1'b0;
        end else begin
            out0_valid <= emit && !own_eff;
            out1_valid <= emit && own_eff;
            out_sop    <= emit && fft_sop_out;
            if (emit) begin
                out_re     <= fft_y_re;
                out_im     <= fft_y_im;
                out_active <= !done;
                ocnt       <= idx + CW'(1);
            end else if (sop_v) out_active <= 1'b0;
            if (pop) out_owner <= tags[rp];
            if ((sop_v && (fcnt == '0 || out_active)) || (fft_valid_out && !fft_sop_out && !out_active))
                err <= 1'b1;
        end
    end
endmodule
